// File: rtl/adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined carry-select adder.
//   DEF_WIDTH/DEF_BLK/DEF_SEG_BLKS : default geometry (32-bit, 4-bit blocks, 2 blocks/segment)
//   nseg()   : number of pipeline segments = latency in cycles
//   seg_ok() : geometry sanity check used at elaboration
package adder_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_BLK      = 4;
  localparam int DEF_SEG_BLKS = 2;

  function automatic int nseg(input int width, input int blk, input int seg_blks);
    return width / (blk * seg_blks);
  endfunction

  function automatic bit seg_ok(input int width, input int blk, input int seg_blks);
    return (blk > 0) && (seg_blks > 0) && (width >= blk * seg_blks) &&
           ((width % (blk * seg_blks)) == 0);
  endfunction

endpackage

// File: rtl/csla_block.sv
// Dual-rail carry-select block: sums for cin=0 and cin=1 are formed in
// parallel and the late-arriving carry only drives the final mux.
//   a, b : BLK-bit operands
//   cin  : block carry-in (select)
//   sum  : BLK-bit result
//   cout : block carry-out
module csla_block
  import adder_pkg::*;
#(
  parameter int BLK = DEF_BLK
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] sum,
  output logic           cout
);

  logic [BLK:0] r0, r1;

  assign r0 = {1'b0, a} + {1'b0, b};
  assign r1 = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};
  assign {cout, sum} = cin ? r1 : r0;

endmodule

// File: rtl/adder_csla_pipe.sv
// Pipelined carry-select adder/subtractor with valid/ready flow control.
// One segment of SEG_BLKS blocks is resolved per stage; the segment carry,
// the partial sum and the not-yet-used operand bits ride down the pipe.
//   i_clk, i_rst      : clock (rising), async active-high reset
//   i_valid/o_ready   : input handshake
//   i_a, i_b          : operands
//   i_carry           : carry-in, add mode only
//   i_sub             : 1 = A - B, 0 = A + B + i_carry
//   o_valid/i_ready   : output handshake
//   o_summ, o_carry   : result mod 2^WIDTH and MSB carry (sub: 1 = no borrow)
module adder_csla_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int BLK      = DEF_BLK,
  parameter int SEG_BLKS = DEF_SEG_BLKS
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_summ,
  output logic             o_carry
);

  localparam int SW   = BLK * SEG_BLKS;
  localparam int NSEG = nseg(WIDTH, BLK, SEG_BLKS);

  if (!seg_ok(WIDTH, BLK, SEG_BLKS)) begin : g_bad_param
    $error("adder_csla_pipe: WIDTH must be a positive multiple of BLK*SEG_BLKS");
  end

  logic [NSEG-1:0] v;
  logic [NSEG-1:0] load;

  // A stage may load if it is empty or everything downstream of it moves;
  // the OR is built from the output end so bubbles anywhere collapse.
  always_comb begin
    logic acc;
    load = '0;
    acc  = i_ready;
    for (int k = NSEG - 1; k >= 0; k--) begin
      acc     = acc | ~v[k];
      load[k] = acc;
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : stg
    localparam int RW = WIDTH - k * SW;  // operand bits still to be added

    logic [RW-1:0]         opa, opb;
    logic                  cin, v_in;
    logic [SW-1:0]         seg_sum;
    logic [(k+1)*SW-1:0]   sum_d, sum_q;
    logic                  cy_q, v_q;

    if (k == 0) begin : g_src
      assign opa   = i_a;
      assign opb   = i_sub ? ~i_b : i_b;
      assign cin   = i_sub | i_carry;
      assign v_in  = i_valid;
      assign sum_d = seg_sum;
    end else begin : g_src
      // Skew register: upper operand bits travel alongside the partial sum.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          opa <= '0;
          opb <= '0;
        end else if (load[k-1]) begin
          opa <= stg[k-1].opa[RW+SW-1:SW];
          opb <= stg[k-1].opb[RW+SW-1:SW];
        end
      end
      assign cin   = stg[k-1].cy_q;
      assign v_in  = stg[k-1].v_q;
      assign sum_d = {seg_sum, stg[k-1].sum_q};
    end

    for (genvar j = 0; j < SEG_BLKS; j++) begin : blk
      logic ci, co;

      if (j == 0) begin : g_ci
        assign ci = cin;
      end else begin : g_ci
        assign ci = blk[j-1].co;
      end

      // Only the very first block sees a carry-in that is known early.
      if (k == 0 && j == 0) begin : g_add
        assign {co, seg_sum[j*BLK +: BLK]} = {1'b0, opa[j*BLK +: BLK]} +
                                             {1'b0, opb[j*BLK +: BLK]} +
                                             {{BLK{1'b0}}, ci};
      end else begin : g_add
        csla_block #(.BLK(BLK)) u_blk (
          .a    (opa[j*BLK +: BLK]),
          .b    (opb[j*BLK +: BLK]),
          .cin  (ci),
          .sum  (seg_sum[j*BLK +: BLK]),
          .cout (co)
        );
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        v_q   <= 1'b0;
        cy_q  <= 1'b0;
        sum_q <= '0;
      end else if (load[k]) begin
        v_q   <= v_in;
        cy_q  <= blk[SEG_BLKS-1].co;
        sum_q <= sum_d;
      end
    end

    assign v[k] = v_q;
  end

  assign o_ready = load[0];
  assign o_valid = v[NSEG-1];
  assign o_summ  = stg[NSEG-1].sum_q;
  assign o_carry = stg[NSEG-1].cy_q;

endmodule

// File: tb/tb_adder_csla_pipe.sv
module tb_adder_csla_pipe;

  logic        clk = 1'b0;
  logic        rst;
  // default-geometry DUT (32-bit, NSEG=4)
  logic        i_valid, o_ready, i_carry, i_sub, o_valid, i_ready, o_carry;
  logic [31:0] i_a, i_b, o_summ;
  // wide DUT (64-bit, BLK=8, SEG_BLKS=1, NSEG=8)
  logic        v2, rdy2, c2, s2, ov2, ir2, oc2;
  logic [63:0] a2, b2, os2;

  logic [32:0] exp_in;
  logic [32:0] q[$];
  logic [32:0] hold_val;
  bit          hold_pend;
  int          n_chk = 0, n_pass = 0, n_out = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  adder_csla_pipe dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_carry(i_carry), .i_sub(i_sub),
    .o_valid(o_valid), .i_ready(i_ready), .o_summ(o_summ), .o_carry(o_carry)
  );

  adder_csla_pipe #(.WIDTH(64), .BLK(8), .SEG_BLKS(1)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_valid(v2), .o_ready(rdy2),
    .i_a(a2), .i_b(b2), .i_carry(c2), .i_sub(s2),
    .o_valid(ov2), .i_ready(ir2), .o_summ(os2), .o_carry(oc2)
  );

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input logic s);
    logic [31:0] be;
    be = s ? ~b : b;
    return {1'b0, a} + {1'b0, be} + {32'd0, (s ? 1'b1 : c)};
  endfunction

  // Scoreboard: inputs and outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) chk("hold_stable", {o_carry, o_summ}, hold_val);
      if (o_valid && i_ready) begin
        n_out++;
        if (q.size() == 0) chk("spurious_out", o_valid, 1'b0);
        else chk("result", {o_carry, o_summ}, q.pop_front());
      end
      if (i_valid && o_ready) q.push_back(exp_in);
      hold_pend = o_valid && !i_ready;
      hold_val  = {o_carry, o_summ};
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic c,
                       input logic s, input logic [32:0] e);
    int  n;
    bit  done;
    logic rdy;
    n = 0; done = 0;
    i_a = a; i_b = b; i_carry = c; i_sub = s; exp_in = e; i_valid = 1'b1;
    while (!done && n < 50) begin
      @(negedge clk); rdy = o_ready;
      @(posedge clk); #1;
      if (rdy) done = 1;
      n++;
    end
    chk("accepted", done, 1'b1);
  endtask

  task automatic issue_rand();
    logic [31:0] a, b;
    logic c, s;
    a = $urandom; b = $urandom; c = 1'($urandom); s = 1'($urandom);
    issue(a, b, c, s, ref_add(a, b, c, s));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("drained", q.size(), 0);
  endtask

  initial begin
    int t0, o0;
    rst = 1'b1;
    i_valid = 0; i_a = 0; i_b = 0; i_carry = 0; i_sub = 0; i_ready = 1; exp_in = 0;
    v2 = 0; a2 = 0; b2 = 0; c2 = 0; s2 = 0; ir2 = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_summ", o_summ, 32'd0);
    chk("rst_carry", o_carry, 1'b0);
    chk("rst_valid64", ov2, 1'b0);
    chk("rst_summ64", os2, 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", o_ready, 1'b1);

    // 1: all-ones + 1, latency 4
    @(posedge clk); #1;
    i_a = 32'hFFFF_FFFF; i_b = 32'h1; i_carry = 0; i_sub = 0;
    exp_in = 33'h1_0000_0000; i_valid = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 0) i_valid = 0;
      if (i < 3) chk("lat_wait", o_valid, 1'b0);
      else begin
        chk("lat_valid", o_valid, 1'b1);
        chk("t1_summ", o_summ, 32'h0);
        chk("t1_carry", o_carry, 1'b1);
      end
    end
    @(posedge clk); #1;

    // 2: directed add/sub vectors, back to back
    issue(32'h0000_0005, 32'h0000_0007, 0, 1, 33'h0_FFFF_FFFE);
    issue(32'h0000_0007, 32'h0000_0005, 0, 1, 33'h1_0000_0002);
    issue(32'h1234_5678, 32'h1234_5678, 0, 1, 33'h1_0000_0000);
    issue(32'h8000_0000, 32'h8000_0000, 1, 0, 33'h1_0000_0001);
    issue(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1, 0, 33'h1_0000_0000);
    issue(32'h0000_0000, 32'h0000_0000, 0, 0, 33'h0_0000_0000);
    issue(32'h0000_0000, 32'h0000_0001, 0, 1, 33'h0_FFFF_FFFF);
    issue(32'h0000_000A, 32'h0000_0003, 1, 1, 33'h1_0000_0007);
    issue(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 33'h0_8000_0000);
    i_valid = 0;
    drain();

    // 3: 100 random ops back to back
    t0 = cyc; o0 = n_out;
    for (int i = 0; i < 100; i++) issue_rand();
    chk("throughput_cycles", cyc - t0, 100);
    i_valid = 0;
    drain();
    chk("rand_count", n_out - o0, 100);

    // 4: backpressure
    o0 = n_out;
    i_ready = 0;
    for (int i = 0; i < 4; i++) issue_rand();
    i_a = 32'hDEAD_BEEF; i_b = 32'h1234_5678; i_carry = 1; i_sub = 0;
    exp_in = ref_add(i_a, i_b, 1'b1, 1'b0); i_valid = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_ready", o_ready, 1'b0);
      chk("bp_valid", o_valid, 1'b1);
      @(posedge clk); #1;
    end
    i_ready = 1;
    issue(32'hDEAD_BEEF, 32'h1234_5678, 1, 0, ref_add(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0));
    issue(32'h0000_1000, 32'h0000_2000, 0, 1, 33'h0_FFFF_F000);
    i_valid = 0;
    drain();
    chk("bp_count", n_out - o0, 6);

    // 5: reset mid-flight
    for (int i = 0; i < 3; i++) issue_rand();
    i_valid = 0;
    @(posedge clk); #1;
    chk("pre_rst_valid", o_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", o_valid, 1'b0);
    chk("rst_async_summ", o_summ, 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    o0 = n_out;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("flushed", o_valid, 1'b0);
    end
    chk("no_stale", n_out - o0, 0);
    issue(32'h0000_0064, 32'h0000_0001, 0, 1, 33'h1_0000_0063);
    i_valid = 0;
    drain();

    // 6: 64-bit, NSEG=8 carry chain
    a2 = 64'hFFFF_FFFF_FFFF_FFFF; b2 = 64'h0; c2 = 1; s2 = 0; v2 = 1;
    #1;
    chk("w64_ready", rdy2, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i == 0) v2 = 0;
      if (i < 7) chk("w64_lat_wait", ov2, 1'b0);
      else begin
        chk("w64_valid", ov2, 1'b1);
        chk("w64_summ", os2, 64'h0);
        chk("w64_carry", oc2, 1'b1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
